// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: 8x8 LED matrix scan sequencer with CPU/display RAM arbitration.
// Each scan slot fetches one row byte from the shared single-port RAM, blanks the
// matrix for a short anti-ghosting gap, then lights that row for a fixed dwell.
// The CPU gets the RAM port in every cycle except the display's FETCH cycle.
// Optional feature: define LED_SCAN_BRIGHTNESS_EN to add the bright[2:0] input,
// which shortens the part of each SHOW phase during which the columns are driven.
module led_scan_ctrl #(
    parameter int ROWS  = 8,
    parameter int DWELL = 16,
    parameter int BLANK = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      base_addr,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [2:0]      bright,
`endif
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [7:0]      cpu_addr,
    input  logic [7:0]      cpu_wdata,
    output logic            cpu_ack,
    output logic [7:0]      cpu_rdata,
    output logic [7:0]      ram_addr,
    output logic            ram_we,
    output logic [7:0]      ram_wdata,
    input  logic [7:0]      ram_rdata,
    output logic [7:0]      led_col,
    output logic [ROWS-1:0] led_row,
    output logic            frame_done
);

    // One counter serves both the BLANK and SHOW phases, so size it for the longer.
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t          state_reg;
    logic [2:0]      row_idx_reg;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      frame_base_reg;
    logic [7:0]      row_buf_reg;
    logic [ROWS-1:0] led_row_reg;
    logic [7:0]      led_col_reg;
    logic            frame_done_reg;
    logic            cpu_ack_reg;
    logic [7:0]      addr_hold_reg;
    logic [7:0]      wdata_hold_reg;

    logic [ROWS-1:0] row_onehot;
    logic [7:0]      fetch_addr;
    logic            grant;
    logic            col_lit;
    logic            last_show;
    logic            last_row;

    // Row select decode: one bit per physical row.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign row_onehot[gi] = (row_idx_reg == 3'(gi));
    end

    // Frame buffer rows are contiguous from frame_base; the address wraps at 8 bits.
    assign fetch_addr = frame_base_reg + {5'd0, row_idx_reg};
    assign last_show  = (cnt_reg == CW'(DWELL - 1));
    assign last_row   = (row_idx_reg == 3'(ROWS - 1));

    // The display owns the port only in FETCH; a completing CPU access (ack high)
    // blocks a new grant so every grant gets exactly one ack cycle.
    assign grant = !reset && cpu_req && !cpu_ack_reg && (state_reg != S_FETCH);

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [2:0]  bright_reg;
    logic [31:0] on_cycles;

    // Columns are driven for the first ((bright+1)*DWELL)/8 cycles of SHOW.
    assign on_cycles = ((32'(bright_reg) + 32'd1) * 32'(DWELL)) >> 3;
    assign col_lit   = (32'(cnt_reg) < on_cycles);
`else
    assign col_lit   = 1'b1;
`endif

    // RAM port mux: display fetch, else CPU grant, else hold the last address/data.
    always_comb begin
        ram_addr  = addr_hold_reg;
        ram_wdata = wdata_hold_reg;
        ram_we    = 1'b0;
        if (state_reg == S_FETCH) begin
            ram_addr = fetch_addr;
        end else if (grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    // Remember what was last on the port so an idle port does not toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_reg  <= 8'h00;
            wdata_hold_reg <= 8'h00;
        end else begin
            addr_hold_reg  <= ram_addr;
            wdata_hold_reg <= ram_wdata;
        end
    end

    // CPU completion: ack lands in the cycle the RAM read data is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack_reg <= 1'b0;
        end else begin
            cpu_ack_reg <= grant;
        end
    end

    // Scan FSM with registered LED outputs (they trail the state by one cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            row_idx_reg    <= 3'd0;
            cnt_reg        <= '0;
            frame_base_reg <= 8'h00;
            row_buf_reg    <= 8'h00;
            led_row_reg    <= '0;
            led_col_reg    <= 8'hFF;
            frame_done_reg <= 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
            bright_reg     <= 3'd7;
`endif
        end else begin
            led_row_reg    <= '0;
            led_col_reg    <= 8'hFF;
            frame_done_reg <= 1'b0;
            if (!enable) begin
                state_reg <= S_IDLE;
                cnt_reg   <= '0;
            end else begin
                unique case (state_reg)
                    S_IDLE: begin
                        frame_base_reg <= base_addr;
`ifdef LED_SCAN_BRIGHTNESS_EN
                        bright_reg     <= bright;
`endif
                        row_idx_reg    <= 3'd0;
                        cnt_reg        <= '0;
                        state_reg      <= S_FETCH;
                    end
                    S_FETCH: begin
                        state_reg <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        row_buf_reg <= ram_rdata;
                        cnt_reg     <= '0;
                        state_reg   <= S_BLANK;
                    end
                    S_BLANK: begin
                        if (cnt_reg == CW'(BLANK - 1)) begin
                            cnt_reg   <= '0;
                            state_reg <= S_SHOW;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    S_SHOW: begin
                        led_row_reg <= row_onehot;
                        led_col_reg <= col_lit ? ~row_buf_reg : 8'hFF;
                        if (last_show) begin
                            cnt_reg   <= '0;
                            state_reg <= S_FETCH;
                            if (last_row) begin
                                // New base (and brightness) only here, so a frame never tears.
                                row_idx_reg    <= 3'd0;
                                frame_done_reg <= 1'b1;
                                frame_base_reg <= base_addr;
`ifdef LED_SCAN_BRIGHTNESS_EN
                                bright_reg     <= bright;
`endif
                            end else begin
                                row_idx_reg <= row_idx_reg + 3'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cpu_ack    = cpu_ack_reg;
    assign cpu_rdata  = ram_rdata;
    assign led_row    = led_row_reg;
    assign led_col    = led_col_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: scoreboard bench for led_scan_ctrl. A timeline model predicts
// each lit row window and frame_done pulse from the scan period arithmetic; CPU
// accesses are predicted from a shadow copy of the RAM. Monitors pop and compare.
module tb_led_scan_ctrl;

    localparam int ROWS   = 8;
    localparam int DWELL  = 16;
    localparam int BLANK  = 2;
    localparam int PERIOD = 2 + BLANK + DWELL;
    localparam int FRAME  = ROWS * PERIOD;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [7:0]      base_addr = 8'h00;
    logic            cpu_req = 1'b0;
    logic            cpu_we = 1'b0;
    logic [7:0]      cpu_addr = 8'h00;
    logic [7:0]      cpu_wdata = 8'h00;
    logic            cpu_ack;
    logic [7:0]      cpu_rdata;
    logic [7:0]      ram_addr;
    logic            ram_we;
    logic [7:0]      ram_wdata;
    logic [7:0]      ram_rdata = 8'h00;
    logic [7:0]      led_col;
    logic [ROWS-1:0] led_row;
    logic            frame_done;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [2:0]      bright = 3'd7;
`endif

    led_scan_ctrl #(.ROWS(ROWS), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .base_addr  (base_addr),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .bright     (bright),
`endif
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .led_col    (led_col),
        .led_row    (led_row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Single-port RAM, 1-cycle synchronous read (read-before-write).
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Posedge count; sampled at negedge it equals the number of edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int row; logic [7:0] col; int start; int stop; } win_t;
    typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } cpu_t;

    win_t       win_q[$];
    int         fd_q[$];
    cpu_t       cpu_q[$];
    logic [7:0] shadow [256];
    int         e_cyc = 0;
    bit         running = 1'b0;

    // Row k of a run occupies the period starting at edge e+k*PERIOD; it is lit
    // after FETCH, CAPTURE and BLANK, and outputs appear one cycle late.
    task automatic push_frame(input int f);
        logic [7:0] base;
        base = base_addr;
        for (int r = 0; r < ROWS; r++) begin
            win_t w;
            int   k;
            k       = f * ROWS + r;
            w.row   = r;
            w.col   = ~shadow[8'(base + 8'(r))];
            w.start = e_cyc + k * PERIOD + 3 + BLANK;
            w.stop  = w.start + DWELL - 1;
            win_q.push_back(w);
        end
        fd_q.push_back(e_cyc + (f + 1) * FRAME);
    endtask

    // The scan stopped at edge d: nothing visible from cycle d onwards.
    task automatic truncate(input int d);
        while (win_q.size() > 0 && win_q[$].start >= d) void'(win_q.pop_back());
        if (win_q.size() > 0 && win_q[$].stop >= d) win_q[win_q.size()-1].stop = d - 1;
        while (fd_q.size() > 0 && fd_q[$] >= d) void'(fd_q.pop_back());
    endtask

    initial begin
        int edge_n;
        forever begin
            @(posedge clk);
            edge_n = cyc + 1;
            if (reset || !enable) begin
                if (running) truncate(edge_n);
                running = 1'b0;
            end else if (!running) begin
                running = 1'b1;
                e_cyc   = edge_n;
                push_frame(0);
            end else if ((edge_n - e_cyc) % FRAME == 0) begin
                push_frame((edge_n - e_cyc) / FRAME);
            end
        end
    end

    // ---------------- monitors ----------------
    bit              in_win = 1'b0;
    bit              gap_bad = 1'b0;
    bit              w_steady;
    int              w_start;
    logic [ROWS-1:0] w_row;
    logic [7:0]      w_col;

    task automatic close_window(input int stop);
        win_t            w;
        logic [ROWS-1:0] exp_row;
        if (win_q.size() == 0) begin
            check(1'b0, "unexpected_row_window", int'(w_row), 0);
        end else begin
            w = win_q.pop_front();
            exp_row = '0;
            exp_row[w.row] = 1'b1;
            $display("row %0d col %02h cycles %0d-%0d", w.row, w_col, w_start, stop);
            check(w_row == exp_row, "row_select", int'(w_row), int'(exp_row));
            check(w_col == w.col, "row_cols", int'(w_col), int'(w.col));
            check(w_start == w.start, "row_start", w_start, w.start);
            check(stop == w.stop, "row_stop", stop, w.stop);
            check(w_steady, "row_steady", 0, 1);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (led_row != '0) begin
                if (!in_win) begin
                    in_win   = 1'b1;
                    w_start  = cyc;
                    w_row    = led_row;
                    w_col    = led_col;
                    w_steady = 1'b1;
                    check(!gap_bad, "blank_cols", int'(gap_bad), 0);
                    gap_bad  = 1'b0;
                end else if (led_row != w_row || led_col != w_col) begin
                    w_steady = 1'b0;
                end
            end else begin
                if (led_col != 8'hFF) gap_bad = 1'b1;
                if (in_win) begin
                    in_win = 1'b0;
                    close_window(cyc - 1);
                end
            end
        end
    end

    initial begin
        int t;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                if (fd_q.size() == 0) begin
                    check(1'b0, "unexpected_frame_done", cyc, 0);
                end else begin
                    t = fd_q.pop_front();
                    $display("frame_done at cycle %0d", cyc);
                    check(cyc == t, "frame_done_time", cyc, t);
                end
            end
        end
    end

    initial begin
        cpu_t c;
        forever begin
            @(negedge clk);
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check(1'b0, "unexpected_cpu_ack", 1, 0);
                end else begin
                    c = cpu_q.pop_front();
                    if (c.we) begin
                        $display("cpu wr addr %02h data %02h", c.addr, c.data);
                    end else begin
                        $display("cpu rd addr %02h data %02h", c.addr, cpu_rdata);
                        check(cpu_rdata == c.data, "cpu_rdata", int'(cpu_rdata), int'(c.data));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cpu_access(input bit we, input logic [7:0] addr, input logic [7:0] data,
                              output int lat);
        cpu_t c;
        c.we   = we;
        c.addr = addr;
        c.data = we ? data : shadow[addr];
        cpu_q.push_back(c);
        if (we) shadow[addr] = data;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 10);
        cpu_req = 1'b0;
        if (!cpu_ack) begin
            check(1'b0, "cpu_ack_timeout", lat, 2);
            void'(cpu_q.pop_back());
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Random CPU traffic: reads anywhere, writes only to 0x20-0x3F (outside every frame).
    task automatic traffic_until(input int t);
        int         lat;
        bit         we;
        logic [7:0] addr;
        while (cyc < t) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            we   = 1'($urandom % 2);
            addr = we ? 8'(8'h20 + ($urandom % 32)) : 8'($urandom % 256);
            cpu_access(we, addr, 8'($urandom), lat);
            check(lat <= 2, "cpu_wait", lat, 2);
        end
        repeat (2) @(negedge clk);
    endtask

    // Index of the next row slot with the given row number.
    function automatic int next_slot(input int row);
        int k;
        k = (cyc - e_cyc) / PERIOD + 1;
        while (k % ROWS != row) k++;
        return k;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         k;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check(led_row == '0, "reset_led_row", int'(led_row), 0);
        check(led_col == 8'hFF, "reset_led_col", int'(led_col), 8'hFF);
        check(cpu_ack == 1'b0, "reset_cpu_ack", int'(cpu_ack), 0);
        check(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Load the whole RAM through the CPU port while the scan is idle.
        for (int a = 0; a < 256; a++) begin
            if (a >= 8'h40 && a <= 8'h47) d = 8'(1 << (a - 8'h40));
            else if (a == 8'h10)          d = 8'hA5;
            else                          d = 8'($urandom);
            cpu_access(1'b1, 8'(a), d, lat);
            check(lat == 1, "idle_cpu_wait", lat, 1);
            @(negedge clk);
        end

        base_addr = 8'h40;
        enable    = 1'b1;
        traffic_until(cyc + 200);

        // CPU read colliding with a FETCH cycle waits one extra cycle.
        k = (cyc - e_cyc) / PERIOD + 1;
        wait_until(e_cyc + k * PERIOD);
        cpu_access(1'b0, 8'h10, 8'h00, lat);
        check(lat == 2, "fetch_collision_wait", lat, 2);
        repeat (2) @(negedge clk);

        // Overwrite row 3 while it is being shown.
        k = next_slot(3);
        wait_until(e_cyc + k * PERIOD + 2 + BLANK + 4);
        cpu_access(1'b1, 8'h43, 8'hFF, lat);
        check(lat <= 2, "cpu_wait", lat, 2);
        traffic_until(cyc + FRAME + 40);

        // Base change mid-frame takes effect only at the next frame.
        k = next_slot(2);
        wait_until(e_cyc + k * PERIOD + 8);
        base_addr = 8'h80;
        traffic_until(cyc + 2 * FRAME);

        // Base near the top of memory wraps to low addresses.
        k = next_slot(1);
        wait_until(e_cyc + k * PERIOD + 8);
        base_addr = 8'hFC;
        traffic_until(cyc + 2 * FRAME);

        // Reset in the middle of row 5's SHOW phase.
        k = next_slot(5);
        wait_until(e_cyc + k * PERIOD + 2 + BLANK + 6);
        reset = 1'b1;
        @(negedge clk);
        check(led_row == '0, "reset_mid_row_led_row", int'(led_row), 0);
        check(led_col == 8'hFF, "reset_mid_row_led_col", int'(led_col), 8'hFF);
        check(frame_done == 1'b0, "reset_mid_row_frame_done", int'(frame_done), 0);
        @(negedge clk);
        reset = 1'b0;
        traffic_until(cyc + FRAME + 40);

        // Drop enable during BLANK, then restart.
        k = (cyc - e_cyc) / PERIOD + 1;
        wait_until(e_cyc + k * PERIOD + 2);
        enable = 1'b0;
        @(negedge clk);
        check(led_row == '0, "disable_led_row", int'(led_row), 0);
        check(led_col == 8'hFF, "disable_led_col", int'(led_col), 8'hFF);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        traffic_until(cyc + FRAME + 30);

        enable = 1'b0;
        repeat (6) @(negedge clk);
        check(win_q.size() == 0, "rows_not_shown", win_q.size(), 0);
        check(fd_q.size() == 0, "frame_done_missing", fd_q.size(), 0);
        check(cpu_q.size() == 0, "cpu_acks_missing", cpu_q.size(), 0);
        check(!gap_bad, "blank_cols_end", int'(gap_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
